// File: rtl/systolic_writeback_if.sv
// Bundle between the writeback stage and its neighbours: tile request/status,
// the diagonal-select/outcome path to the systolic array, and the output SRAM write port.
interface systolic_writeback_if #(
  parameter int ARRAY_SIZE      = 16,
  parameter int OUTCOME_WIDTH   = 21,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10
);
  logic                                start;
  logic [ADDR_WIDTH-1:0]               base_addr;
  logic [3:0]                          shift;
  logic                                relu_en;
  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome;
  logic [5:0]                          matrix_index;
  logic                                sram_wen;
  logic [ADDR_WIDTH-1:0]               sram_waddr;
  logic [SRAM_DATA_WIDTH-1:0]          sram_wdata0;
  logic [SRAM_DATA_WIDTH-1:0]          sram_wdata1;
  logic [SRAM_DATA_WIDTH-1:0]          sram_wdata2;
  logic [SRAM_DATA_WIDTH-1:0]          sram_wdata3;
  logic                                busy;
  logic                                done;

  modport slave (
    input  start, base_addr, shift, relu_en, mul_outcome,
    output matrix_index, sram_wen, sram_waddr,
           sram_wdata0, sram_wdata1, sram_wdata2, sram_wdata3, busy, done
  );

  modport master (
    output start, base_addr, shift, relu_en, mul_outcome,
    input  matrix_index, sram_wen, sram_waddr,
           sram_wdata0, sram_wdata1, sram_wdata2, sram_wdata3, busy, done
  );
endinterface

// File: rtl/systolic_writeback.sv
// Systolic array output stage: sweeps the 16 diagonals, quantizes each 21-bit lane
// to 8 bits (round, shift, saturate, optional ReLU) and writes 4 packed words per diagonal.

module sw_lane_quant #(
  parameter int OUTCOME_WIDTH = 21,
  parameter int DATA_WIDTH    = 8
) (
  input  logic signed [OUTCOME_WIDTH-1:0] x,
  input  logic [3:0]                      shift,
  input  logic                            relu_en,
  output logic [DATA_WIDTH-1:0]           q
);
  localparam int RW = OUTCOME_WIDTH + 1;
  localparam logic signed [RW-1:0] QMAX = RW'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [RW-1:0] QMIN = ~QMAX;

  logic [RW-1:0]        rnd;
  logic signed [RW-1:0] r;
  logic signed [RW-1:0] y;

  always_comb begin
    // half-LSB rounding constant; collapses to 0 when shift is 0
    rnd = (RW'(1) << shift) >> 1;
    r   = $signed({x[OUTCOME_WIDTH-1], x}) + $signed(rnd);
    y   = r >>> shift;
    if (y > QMAX)      q = QMAX[DATA_WIDTH-1:0];
    else if (y < QMIN) q = QMIN[DATA_WIDTH-1:0];
    else               q = y[DATA_WIDTH-1:0];
    if (relu_en && q[DATA_WIDTH-1]) q = '0;
  end
endmodule

module systolic_writeback #(
  parameter int ARRAY_SIZE      = 16,
  parameter int DATA_WIDTH      = 8,
  parameter int OUTCOME_WIDTH   = 21,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10
) (
  input  logic                 clk,
  input  logic                 srstn,
  systolic_writeback_if.slave  bus
);
  localparam int STAGES         = 2;
  localparam int IDX_W          = $clog2(ARRAY_SIZE);
  localparam int LANES_PER_WORD = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int NUM_WORDS      = ARRAY_SIZE / LANES_PER_WORD;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t                                      state, state_nxt;
  logic                                        accept;
  logic [IDX_W-1:0]                            idx;
  logic                                        drain_cnt;
  logic                                        done_q;
  logic [ADDR_WIDTH-1:0]                       base_q;
  logic [3:0]                                  shift_q;
  logic                                        relu_q;
  logic [STAGES:1]                             vld_pipe;
  logic [ARRAY_SIZE-1:0][OUTCOME_WIDTH-1:0]    cap_data;
  logic [IDX_W-1:0]                            cap_idx;
  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]       q;
  logic [NUM_WORDS-1:0][SRAM_DATA_WIDTH-1:0]   packed_w;
  logic [NUM_WORDS-1:0][SRAM_DATA_WIDTH-1:0]   wdata;
  logic [ADDR_WIDTH-1:0]                       waddr;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin
               accept    = 1'b1;
               state_nxt = SWEEP;
             end
      SWEEP: if (idx == IDX_W'(ARRAY_SIZE-1)) state_nxt = DRAIN;
      DRAIN: if (drain_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sweep counter holds its last value (ARRAY_SIZE-1) until the next tile.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      idx       <= '0;
      drain_cnt <= 1'b0;
      done_q    <= 1'b0;
      base_q    <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
    end else begin
      if (accept) begin
        idx     <= '0;
        base_q  <= bus.base_addr;
        shift_q <= bus.shift;
        relu_q  <= bus.relu_en;
      end else if (state == SWEEP && idx != IDX_W'(ARRAY_SIZE-1)) begin
        idx <= idx + IDX_W'(1);
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      done_q    <= (state == DRAIN) && drain_cnt;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      vld_pipe <= '0;
      cap_data <= '0;
      cap_idx  <= '0;
      wdata    <= '0;
      waddr    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], state == SWEEP};
      if (state == SWEEP) begin
        cap_data <= bus.mul_outcome;
        cap_idx  <= idx;
      end
      // address and data hold between writes
      if (vld_pipe[1]) begin
        wdata <= packed_w;
        waddr <= base_q + ADDR_WIDTH'(cap_idx);
      end
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    sw_lane_quant #(
      .OUTCOME_WIDTH (OUTCOME_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
    ) u_lane (
      .x       (cap_data[i]),
      .shift   (shift_q),
      .relu_en (relu_q),
      .q       (q[i])
    );
  end

  // lowest-numbered lane lands in the most significant byte of its word
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    for (genvar b = 0; b < LANES_PER_WORD; b++) begin : g_byte
      assign packed_w[w][SRAM_DATA_WIDTH-1-DATA_WIDTH*b -: DATA_WIDTH] = q[LANES_PER_WORD*w + b];
    end
  end

  assign bus.matrix_index = {{(6-IDX_W){1'b0}}, idx};
  assign bus.sram_wen     = vld_pipe[STAGES];
  assign bus.sram_waddr   = waddr;
  assign bus.sram_wdata0  = wdata[0];
  assign bus.sram_wdata1  = wdata[1];
  assign bus.sram_wdata2  = wdata[2];
  assign bus.sram_wdata3  = wdata[3];
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;
endmodule

// File: tb/tb_systolic_writeback.sv
// Directed bench for systolic_writeback: reset/idle, identity, quantization table,
// address wrap with back-to-back tiles, and reset in the middle of a sweep.
module tb_systolic_writeback;
  localparam int AS = 16;
  localparam int OW = 21;
  localparam int AW = 10;
  localparam int SW = 32;

  logic clk = 1'b0;
  logic srstn;
  always #5 clk = ~clk;

  systolic_writeback_if #(.ARRAY_SIZE(AS), .OUTCOME_WIDTH(OW),
                          .SRAM_DATA_WIDTH(SW), .ADDR_WIDTH(AW)) bus();

  systolic_writeback #(.ARRAY_SIZE(AS), .DATA_WIDTH(8), .OUTCOME_WIDTH(OW),
                       .SRAM_DATA_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .srstn (srstn),
    .bus   (bus)
  );

  typedef enum int {M_TBL, M_ID, M_DIAG} mode_t;

  typedef struct {
    logic [AW-1:0]        base;
    logic [3:0]           shift;
    logic                 relu;
    logic signed [OW-1:0] x0, x1, x2, x3;
    logic [31:0]          exp;
  } vec_t;

  mode_t                mode = M_TBL;
  logic signed [OW-1:0] cur_x [4];
  logic [31:0]          cur_exp;
  mode_t                nxt_mode;
  logic [AW-1:0]        nxt_base;
  int                   pass_cnt = 0;
  int                   total = 0;
  vec_t                 tbl [6];

  // Array model: lane value is a pure function of the current diagonal select.
  always_comb begin
    bus.mul_outcome = '0;
    for (int i = 0; i < AS; i++) begin
      case (mode)
        M_ID:    bus.mul_outcome[i*OW +: OW] = OW'(i);
        M_DIAG:  bus.mul_outcome[i*OW +: OW] = OW'(bus.matrix_index);
        default: bus.mul_outcome[i*OW +: OW] = cur_x[i%4];
      endcase
    end
  end

  function automatic logic [31:0] exp_word(int w, int k);
    case (mode)
      M_ID:    return {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
      M_DIAG:  return {4{8'(k)}};
      default: return cur_exp;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " matrix_index"}, 32'(bus.matrix_index), 32'd0);
    chk({tag, " sram_wen"},     32'(bus.sram_wen),     32'd0);
    chk({tag, " sram_waddr"},   32'(bus.sram_waddr),   32'd0);
    chk({tag, " wdata0"},       bus.sram_wdata0,       32'd0);
    chk({tag, " wdata1"},       bus.sram_wdata1,       32'd0);
    chk({tag, " wdata2"},       bus.sram_wdata2,       32'd0);
    chk({tag, " wdata3"},       bus.sram_wdata3,       32'd0);
    chk({tag, " busy"},         32'(bus.busy),         32'd0);
    chk({tag, " done"},         32'(bus.done),         32'd0);
  endtask

  // Caller has raised start before the accepting edge. Scrambles the latched
  // inputs after accept and pokes start during SWEEP and DRAIN (must be ignored).
  task automatic check_tile(input logic [AW-1:0] base, input logic chain);
    logic [AW-1:0] ea;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.base_addr = ~base;
    bus.shift     = ~bus.shift;
    bus.relu_en   = ~bus.relu_en;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      chk("matrix_index", 32'(bus.matrix_index), (n <= 16) ? 32'(n-1) : 32'd15);
      if (n >= 3 && n <= 18) begin
        ea = base + AW'(n-3);
        chk("sram_wen write",  32'(bus.sram_wen),   32'd1);
        chk("sram_waddr",      32'(bus.sram_waddr), 32'(ea));
        chk("sram_wdata0",     bus.sram_wdata0,     exp_word(0, n-3));
        chk("sram_wdata1",     bus.sram_wdata1,     exp_word(1, n-3));
        chk("sram_wdata2",     bus.sram_wdata2,     exp_word(2, n-3));
        chk("sram_wdata3",     bus.sram_wdata3,     exp_word(3, n-3));
      end else begin
        chk("sram_wen quiet",  32'(bus.sram_wen),   32'd0);
      end
      chk("busy", 32'(bus.busy), (n <= 18) ? 32'd1 : 32'd0);
      chk("done", 32'(bus.done), (n == 19) ? 32'd1 : 32'd0);
      if (n == 19) begin
        ea = base + AW'(15);
        chk("sram_waddr hold",  32'(bus.sram_waddr), 32'(ea));
        chk("sram_wdata3 hold", bus.sram_wdata3,     exp_word(3, 15));
        if (chain) begin
          bus.start     = 1'b1;
          bus.base_addr = nxt_base;
          bus.shift     = 4'd0;
          bus.relu_en   = 1'b0;
          mode          = nxt_mode;
        end
      end
      if (n == 5 || n == 17) bus.start = 1'b1;
      if (n == 6 || n == 18) bus.start = 1'b0;
    end
  endtask

  task automatic launch(input mode_t m, input logic [AW-1:0] base,
                        input logic [3:0] sh, input logic relu);
    mode          = m;
    bus.base_addr = base;
    bus.shift     = sh;
    bus.relu_en   = relu;
    bus.start     = 1'b1;
  endtask

  initial begin
    int bad;
    tbl[0] = '{10'd100, 4'd4,  1'b0, 21'sd24,    -21'sd24,    21'sd5000,  21'h100000, 32'h02FF7F80};
    tbl[1] = '{10'd200, 4'd0,  1'b1, -21'sd5,    21'sd5,      21'h100000, 21'sd127,   32'h0005007F};
    tbl[2] = '{10'd300, 4'd0,  1'b0, 21'sd128,   -21'sd129,   -21'sd128,  -21'sd1,    32'h7F8080FF};
    tbl[3] = '{10'd400, 4'd1,  1'b0, 21'sd3,     -21'sd3,     21'sd1,     -21'sd1,    32'h02FF0100};
    tbl[4] = '{10'd500, 4'd15, 1'b0, 21'sd16384, -21'sd16385, 21'h0FFFFF, -21'sd16384, 32'h01FF2000};
    tbl[5] = '{10'd600, 4'd4,  1'b1, -21'sd8,    -21'sd9,     21'h100000, 21'h0FFFFF, 32'h0000007F};
    for (int i = 0; i < 4; i++) cur_x[i] = '0;
    cur_exp       = '0;
    nxt_mode      = M_ID;
    nxt_base      = '0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.shift     = '0;
    bus.relu_en   = 1'b0;
    srstn         = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_vals("in reset");
    srstn = 1'b1;

    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.sram_wen !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    chk("idle quiet cycles", 32'(bad), 32'd0);
    chk_reset_vals("after idle");

    @(negedge clk);
    launch(M_ID, 10'h040, 4'd0, 1'b0);
    check_tile(10'h040, 1'b0);

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      cur_x[0] = tbl[v].x0;
      cur_x[1] = tbl[v].x1;
      cur_x[2] = tbl[v].x2;
      cur_x[3] = tbl[v].x3;
      cur_exp  = tbl[v].exp;
      launch(M_TBL, tbl[v].base, tbl[v].shift, tbl[v].relu);
      check_tile(tbl[v].base, 1'b0);
    end

    // wrap past the top of the address space, then chain a tile in the done cycle
    @(negedge clk);
    nxt_mode = M_ID;
    nxt_base = 10'd5;
    launch(M_DIAG, 10'd1020, 4'd0, 1'b0);
    check_tile(10'd1020, 1'b1);
    check_tile(10'd5, 1'b0);

    @(negedge clk);
    launch(M_ID, 10'd50, 4'd0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(negedge clk);
    srstn = 1'b0;
    #1;
    chk_reset_vals("mid-sweep reset");
    repeat (3) @(negedge clk);
    srstn = 1'b1;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.sram_wen !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("no activity after reset", 32'(bad), 32'd0);
    launch(M_ID, 10'd50, 4'd0, 1'b0);
    check_tile(10'd50, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/systolic_writeback.md
# systolic_writeback

Output stage directly downstream of the 16x16 systolic array. After the array finishes accumulating, this block sweeps the array's `matrix_index` select across all 16 output diagonals and captures each 16-lane, 21-bit `mul_outcome` vector. It rounds, shifts, saturates and optionally ReLUs each lane to 8 bits, then writes the packed result to the output SRAM as four 32-bit words per diagonal.

## Interface
- `ARRAY_SIZE`, 16, lanes per diagonal and number of diagonals (block is specified for 16).
- `DATA_WIDTH`, 8, quantized output width.
- `OUTCOME_WIDTH`, 21, accumulator lane width (2*DATA_WIDTH+5).
- `SRAM_DATA_WIDTH`, 32, output SRAM word width (4 lanes per word).
- `ADDR_WIDTH`, 10, output SRAM address width.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `srstn`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle request to write back one finished tile.
- `base_addr`  in  ADDR_WIDTH  SRAM address for diagonal 0; latched on accepted start.
- `shift`  in  4  right-shift amount 0..15; latched on accepted start.
- `relu_en`  in  1  clamp negatives to 0; latched on accepted start.
- `mul_outcome`  in  ARRAY_SIZE*OUTCOME_WIDTH  from the array; lane i at bits [i*21 +: 21], signed.
- `matrix_index`  out  6  diagonal select to the array.
- `sram_wen`  out  1  active-high write strobe, one cycle per diagonal.
- `sram_waddr`  out  ADDR_WIDTH  write address.
- `sram_wdata0`..`sram_wdata3`  out  32 each  packed lanes 0-3, 4-7, 8-11, 12-15.
- `busy`  out  1  high from accepted start until done.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, SWEEP, DRAIN.
- IDLE: `start`=1 is accepted, latching `base_addr`, `shift` and `relu_en`. The FSM moves to SWEEP with index counter = 0.
- SWEEP: `matrix_index` = counter, 0..15, incrementing every cycle. After driving 15, the FSM moves to DRAIN.
- DRAIN: 2 cycles to flush the pipeline, then IDLE with a `done` pulse.
- `start` is ignored in SWEEP and DRAIN. It is not queued.
- Pipeline stage 1, capture: register `mul_outcome` together with its index.
- Pipeline stage 2, quantize: register the packed words, address and `sram_wen`=1.
- Lane arithmetic, per lane x (21-bit signed):
  - r = x + (shift>0 ? 1<<(shift-1) : 0), computed at 22 bits, no overflow.
  - y = r >>> shift (arithmetic).
  - Saturate to [-128, 127].
  - If `relu_en` and y<0, y = 0.
- Packing: lane 4w+b goes to `sram_wdataw`[31-8b -: 8]. Lane 0 is the MSB byte of word 0, matching the array's input byte order.
- Address for diagonal k is `base_addr` + k, modulo 2^ADDR_WIDTH (wraps silently).
- Diagonal k content: lane i holds C[i][(k-i) mod 16]. Column de-rotation is the consumer's job; this block does not reorder.
- Reset while busy: all state clears immediately, no further writes, and no `done`.

## Timing
- Reset values:
  - `matrix_index`=0, `sram_wen`=0, `sram_waddr`=0, all `sram_wdata`=0, `busy`=0, `done`=0.
  - FSM is in IDLE.
- Let T0 be the edge where `start` is accepted.
- `busy`=1 from T0 onward.
- `matrix_index`=k during cycle T0+1+k, for k=0..15.
- `mul_outcome` is treated as combinational from `matrix_index` and is sampled at the end of that cycle.
- `sram_wen`=1 with diagonal k's address and data during cycle T0+3+k, for k=0..15. That is 16 consecutive write cycles, no gaps.
- `sram_wen`=0 in all other cycles. Data and address hold their last values when `sram_wen`=0.
- `done`=1 for exactly cycle T0+19. `busy` falls at the same edge that raises `done`.
- A `start` in cycle T0+19, while `done` is high, is accepted: back-to-back tiles are allowed.
- `matrix_index` holds 15 after the sweep until the next start.

## Test plan
- Reset then idle: no `start` for 50 cycles -> `sram_wen` never 1, all outputs at reset values.
- Identity pass: shift=0, relu_en=0, every lane = lane index i -> 16 writes at base..base+15, each word0=0x00010203, word3=0x0C0D0E0F; done at T0+19.
- Rounding and saturation: shift=4, lanes = 24 (->2), -24 (->-1), 5000 (->127 sat), -1048576 (->-128 sat) -> bytes 0x02, 0xFF, 0x7F, 0x80.
- ReLU: relu_en=1, shift=0, lane = -5 -> byte 0x00; lane = 5 -> 0x05.
- Address wrap and back-to-back: base_addr=1020 (ADDR_WIDTH=10) -> addresses 1020..1023 then 0..11. Second start in the done cycle -> second sweep writes start at T0'+3 with no overlap.
- Reset mid-sweep: assert srstn=0 at T0+8 -> outputs at reset values immediately, no `done`. After release, a new start yields the full 16 writes.
